fla_mem_rsp: RTL and testbench
==============================

// Module: fla_mem_rsp
// PURPOSE
//  Memory-side responder for the fla_hbm request interface (f2m_*/m2f_*).
//  Accepts one burst request at a time and range-checks it. Moves 1..MAX_LEN words
//  between the requester and a single-port memory master port (mem_*).
//  Signals end of each burst with a one-cycle m2f_ack. Sits between the DMA-engine
//  initiators and the memory arbiter.
// PARAMETERS
//  MAX_LEN   32         largest legal f2m_len (words); larger -> violation
//  MAX_OUT   4          max outstanding memory reads (1..7)
//  WIN_LO    24'h000000 first legal word address (f2m_addr[25:2])
//  WIN_HI    24'h3FFFFF last legal word address
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-low
//  f2m_req      in   1   request; held high by initiator until cycle after m2f_ack
//  f2m_write    in   1   0=memory->requester (read), 1=requester->memory (write)
//  f2m_addr     in   24  [25:2] start word address
//  f2m_len      in   6   burst length in words, one-based
//  dma_hwdata   in   32  write data from requester
//  m2f_ack      out  1   one-cycle end-of-transaction pulse
//  m2f_viol     out  1   asserted only together with m2f_ack: illegal request
//  m2f_fwvalid  out  1   dma_hrdata valid this cycle (read bursts)
//  m2f_frvalid  out  1   dma_hwdata consumed this cycle (write bursts)
//  dma_hrdata   out  32  read data to requester
//  mem_req      out  1   memory access request
//  mem_we       out  1   1=write
//  mem_addr     out  24  word address
//  mem_wdata    out  32  write data
//  mem_gnt      in   1   access accepted this cycle
//  mem_rvalid   in   1   read data returned (in order, any latency >=1)
//  mem_rdata    in   32  read data
// BEHAVIOUR
//  Reset: all outputs 0. State = IDLE. Counters = 0. Reset mid-burst aborts silently, with no ack.
//  FSM: IDLE -> CHK (f2m_req=1 and not the cycle after an ack; capture addr/len/write)
//   CHK  -> ACK with m2f_viol=1 if len==0, len>MAX_LEN, or [addr, addr+len-1] exceeds
//           WIN_LO..WIN_HI or wraps past 24'hFFFFFF; otherwise -> XFER. CHK lasts 1 cycle.
//   XFER (read): mem_req=1 while issued<len and outstanding<MAX_OUT. Issued/outstanding
//        counters update on mem_gnt. Each mem_rvalid registers mem_rdata into dma_hrdata
//        and pulses m2f_fwvalid the next cycle. Simultaneous gnt and rvalid leaves
//        outstanding unchanged. After the len-th fwvalid -> ACK.
//   XFER (write): mem_req=1, mem_we=1, mem_wdata=dma_hwdata (combinational).
//        m2f_frvalid=mem_gnt (combinational). After the len-th gnt -> ACK.
//   ACK: m2f_ack=1 for exactly 1 cycle, then -> IDLE. The IDLE re-arm is blocked for the
//        following cycle because f2m_req is still high there.
//  mem_addr = captured addr + issued count. Arithmetic is 24-bit, but the window check
//  guarantees no wrap. dma_hrdata holds its last value between strobes.
//  Read data never stalls: the requester must accept every fwvalid.
//  f2m_* changes during CHK/XFER/ACK are ignored (captured copies used).
// CONFIGURATION
//  FLA_RSP_WINCHK_EN defined: the window/wrap check is active as above.
//  Not defined: only the len==0 and len>MAX_LEN checks raise m2f_viol. WIN_LO/WIN_HI are
//  unused, and the window comparators are not built.
// STRUCTURE
//  fla_hbm_defs.v (shared include): FSM state encodings, FLA_LEN_W=6, FLA_ADDR_W=24,
//  viol-cause codes.
//  One sub-module, fla_rsp_beatcnt: issued/outstanding/returned counters with
//  done/credit flags. The FSM and datapath stay in fla_mem_rsp.
// TESTING
//  1. Read addr=24'h000100 len=16, rvalid latency 3 -> 16 fwvalid with data from
//     0x100..0x10F in order, then one ack, viol=0; mem_req never exceeds 4 outstanding.
//  2. Write addr=24'h000200 len=8, gnt every other cycle -> 8 frvalid coincident with
//     gnt, memory words 0x200..0x207 written, ack, viol=0.
//  3. len=0, then len=33 -> ack with viol=1 two cycles after req, no mem_req, no valids.
//  4. WINCHK_EN, WIN_HI=24'h3FFFFF, addr=24'h3FFFF8 len=16 -> ack+viol, no memory
//     access. Macro off: the same request completes normally.
//  5. Back-to-back: initiator re-raises req two cycles after ack -> second burst
//     accepted. req held one extra cycle -> no duplicate transaction.
//  6. Reset asserted mid-read after 5 of 16 words -> all outputs 0 immediately.
//     After release, a new request completes normally.

Source files
------------

// File: rtl/fla_mem_rsp_pkg.sv
// fla_mem_rsp_pkg: shared widths, FSM states, violation causes and the
// captured-burst bundle for the fla_hbm memory-side responder.
package fla_mem_rsp_pkg;

    localparam int FLA_LEN_W  = 6;
    localparam int FLA_ADDR_W = 24;
    localparam int FLA_OUT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHK  = 2'd1,
        ST_XFER = 2'd2,
        ST_ACK  = 2'd3
    } rsp_state_e;

    typedef enum logic [1:0] {
        VC_NONE = 2'd0,
        VC_LEN0 = 2'd1,
        VC_LONG = 2'd2,
        VC_WIN  = 2'd3
    } viol_cause_e;

    typedef struct packed {
        logic                  write;
        logic [FLA_ADDR_W-1:0] addr;
        logic [FLA_LEN_W-1:0]  len;
    } burst_t;

    // Last word touched by a burst, one bit wider so a 24-bit wrap is visible.
    function automatic logic [FLA_ADDR_W:0] last_word(
        input logic [FLA_ADDR_W-1:0] a,
        input logic [FLA_LEN_W-1:0]  l
    );
        return {1'b0, a}
             + {{(FLA_ADDR_W-FLA_LEN_W+1){1'b0}}, l}
             - (FLA_ADDR_W+1)'(1);
    endfunction

endpackage

// File: rtl/fla_rsp_beatcnt.sv
// fla_rsp_beatcnt: issued / outstanding / returned beat counters of one
// burst, with the done and credit flags the responder FSM steers on.
module fla_rsp_beatcnt
    import fla_mem_rsp_pkg::*;
#(
    parameter int MAX_OUT = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic [FLA_LEN_W-1:0] i_len,
    input  logic                 i_gnt,
    input  logic                 i_gnt_rd,
    input  logic                 i_rvalid,
    output logic [FLA_LEN_W-1:0] o_issued,
    output logic                 o_credit,
    output logic                 o_all_issued,
    output logic                 o_last_issue,
    output logic                 o_all_returned
);

    localparam logic [FLA_OUT_W-1:0] LP_MAX_OUT = FLA_OUT_W'(MAX_OUT);

    logic [FLA_LEN_W-1:0] r_issued;
    logic [FLA_OUT_W-1:0] r_outst;
    logic [FLA_LEN_W-1:0] r_returned;

    // Count accepted accesses and returned read beats for the current burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued   <= '0;
            r_returned <= '0;
        end else if (i_clr) begin
            r_issued   <= '0;
            r_returned <= '0;
        end else begin
            if (i_gnt)
                r_issued <= r_issued + FLA_LEN_W'(1);
            if (i_rvalid)
                r_returned <= r_returned + FLA_LEN_W'(1);
        end
    end

    // Reads in flight; a grant and a return in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outst <= '0;
        end else if (i_clr) begin
            r_outst <= '0;
        end else begin
            unique case ({i_gnt_rd, i_rvalid})
                2'b10:   r_outst <= r_outst + FLA_OUT_W'(1);
                2'b01:   r_outst <= r_outst - FLA_OUT_W'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    assign o_issued       = r_issued;
    assign o_credit       = (r_outst < LP_MAX_OUT);
    assign o_all_issued   = (r_issued == i_len);
    assign o_last_issue   = ((r_issued + FLA_LEN_W'(1)) == i_len);
    assign o_all_returned = (r_returned == i_len);

endmodule

// File: rtl/fla_mem_rsp.sv
// fla_mem_rsp: memory-side responder for fla_hbm bursts (check, move, ack).
// Define FLA_RSP_WINCHK_EN to build the WIN_LO..WIN_HI / wrap range check.
module fla_mem_rsp
    import fla_mem_rsp_pkg::*;
#(
    parameter int                    MAX_LEN = 32,
    parameter int                    MAX_OUT = 4,
    parameter logic [FLA_ADDR_W-1:0] WIN_LO  = 24'h000000,
    parameter logic [FLA_ADDR_W-1:0] WIN_HI  = 24'h3FFFFF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f2m_req,
    input  logic                  f2m_write,
    input  logic [FLA_ADDR_W-1:0] f2m_addr,
    input  logic [FLA_LEN_W-1:0]  f2m_len,
    input  logic [31:0]           dma_hwdata,
    output logic                  m2f_ack,
    output logic                  m2f_viol,
    output logic                  m2f_fwvalid,
    output logic                  m2f_frvalid,
    output logic [31:0]           dma_hrdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [FLA_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam logic [FLA_LEN_W:0] LP_MAX_LEN = (FLA_LEN_W+1)'(MAX_LEN);

    rsp_state_e           r_state;
    rsp_state_e           w_next;
    burst_t               r_burst;
    logic                 r_block;
    logic                 r_viol;
    logic                 r_fwvalid;
    logic [31:0]          r_hrdata;
    viol_cause_e          w_cause;
    logic                 w_go;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_mem_req;
    logic                 w_gnt;
    logic                 w_done;
    logic [FLA_LEN_W-1:0] w_issued;
    logic                 w_credit;
    logic                 w_all_issued;
    logic                 w_last_issue;
    logic                 w_all_returned;

    assign w_go      = f2m_req & ~r_block;
    assign w_rd      = (r_state == ST_XFER) & ~r_burst.write;
    assign w_wr      = (r_state == ST_XFER) & r_burst.write;
    assign w_mem_req = w_wr | (w_rd & ~w_all_issued & w_credit);
    assign w_gnt     = mem_gnt & w_mem_req;
    assign w_done    = r_burst.write ? (w_gnt & w_last_issue)
                                     : (r_fwvalid & w_all_returned);

`ifdef FLA_RSP_WINCHK_EN
    logic [FLA_ADDR_W:0] w_last;
    assign w_last = last_word(r_burst.addr, r_burst.len);
`else
    logic w_unused_win;
    assign w_unused_win = ^{WIN_LO, WIN_HI};
`endif

    // Classify the captured request; first failing rule wins.
    always_comb begin
        w_cause = VC_NONE;
        if (r_burst.len == '0)
            w_cause = VC_LEN0;
        else if ({1'b0, r_burst.len} > LP_MAX_LEN)
            w_cause = VC_LONG;
`ifdef FLA_RSP_WINCHK_EN
        else if (r_burst.addr < WIN_LO || w_last[FLA_ADDR_W]
                 || w_last[FLA_ADDR_W-1:0] > WIN_HI)
            w_cause = VC_WIN;
`endif
    end

    fla_rsp_beatcnt #(
        .MAX_OUT (MAX_OUT)
    ) u_beatcnt (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (r_state == ST_CHK),
        .i_len          (r_burst.len),
        .i_gnt          (w_gnt),
        .i_gnt_rd       (w_gnt & ~r_burst.write),
        .i_rvalid       (w_rd & mem_rvalid),
        .o_issued       (w_issued),
        .o_credit       (w_credit),
        .o_all_issued   (w_all_issued),
        .o_last_issue   (w_last_issue),
        .o_all_returned (w_all_returned)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_go) w_next = ST_CHK;
            ST_CHK:  w_next = (w_cause != VC_NONE) ? ST_ACK : ST_XFER;
            ST_XFER: if (w_done) w_next = ST_ACK;
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture request, verdict and read data; block re-arm right after ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst   <= '0;
            r_block   <= 1'b0;
            r_viol    <= 1'b0;
            r_fwvalid <= 1'b0;
            r_hrdata  <= '0;
        end else begin
            r_block   <= (r_state == ST_ACK);
            r_fwvalid <= w_rd & mem_rvalid;
            if (r_state == ST_IDLE && w_go)
                r_burst <= {f2m_write, f2m_addr, f2m_len};
            if (r_state == ST_CHK)
                r_viol <= (w_cause != VC_NONE);
            if (w_rd & mem_rvalid)
                r_hrdata <= mem_rdata;
        end
    end

    // Output decode.
    always_comb begin
        m2f_ack     = (r_state == ST_ACK);
        m2f_viol    = (r_state == ST_ACK) & r_viol;
        m2f_fwvalid = r_fwvalid;
        m2f_frvalid = w_wr & mem_gnt;
        dma_hrdata  = r_hrdata;
        mem_req     = w_mem_req;
        mem_we      = w_wr;
        mem_addr    = r_burst.addr
                    + {{(FLA_ADDR_W-FLA_LEN_W){1'b0}}, w_issued};
        mem_wdata   = w_wr ? dma_hwdata : '0;
    end

endmodule

// File: tb/tb_fla_mem_rsp.sv
// tb_fla_mem_rsp: randomized bench for fla_mem_rsp with a word-level memory
// model, a latency-queue read responder and per-scenario check tasks.
module tb_fla_mem_rsp;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        f2m_req    = 1'b0;
    logic        f2m_write  = 1'b0;
    logic [23:0] f2m_addr   = '0;
    logic [5:0]  f2m_len    = '0;
    logic [31:0] dma_hwdata = '0;
    logic        mem_gnt    = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = '0;
    logic        m2f_ack, m2f_viol, m2f_fwvalid, m2f_frvalid;
    logic [31:0] dma_hrdata, mem_wdata;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;

    fla_mem_rsp dut (
        .clk(clk), .rst(rst),
        .f2m_req(f2m_req), .f2m_write(f2m_write),
        .f2m_addr(f2m_addr), .f2m_len(f2m_len),
        .dma_hwdata(dma_hwdata),
        .m2f_ack(m2f_ack), .m2f_viol(m2f_viol),
        .m2f_fwvalid(m2f_fwvalid), .m2f_frvalid(m2f_frvalid),
        .dma_hrdata(dma_hrdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int rdy; } pend_t;

    int          n_vec = 0, n_bad = 0, cyc = 0;
    int          gnt_mode = 0, lat_min = 1, lat_max = 1;
    logic        gnt_tgl = 1'b0, req_q = 1'b0;
    pend_t       pq[$];
    logic [31:0] wmem [logic [23:0]];
    logic [31:0] rd_got[$], wr_dat[$], exp_rd[$];
    logic [23:0] wr_addr[$];
    logic [31:0] wsrc [0:63];
    int          wbeat = 0, n_ack = 0, n_viol = 0, n_memreq = 0, n_fr = 0;
    int          max_out = 0, bad_frv = 0, ack_cyc = 0, req_cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (wmem.exists(a)) return wmem[a];
        return {a[11:0], 8'hC3, a[23:12]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_viol(input logic [23:0] a, input logic [5:0] l);
        bit v;
        v = (l == 0) || (l > 32);
`ifdef FLA_RSP_WINCHK_EN
        v = v || (int'(a) + int'(l) - 1 > 'h3FFFFF);
`endif
        return v;
    endfunction

    // Memory model and monitor: drive at negedge, observe 1ns later.
    always @(negedge clk) begin
        cyc++;
        dma_hwdata = wsrc[wbeat & 63];
        case (gnt_mode)
            0: mem_gnt = 1'b1;
            1: begin gnt_tgl = ~gnt_tgl; mem_gnt = gnt_tgl; end
            default: mem_gnt = ($urandom_range(0, 2) != 0);
        endcase
        if (pq.size() > 0 && pq[0].rdy <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pq[0].d;
            void'(pq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #1;
        if (rst) begin
            if (m2f_fwvalid) rd_got.push_back(dma_hrdata);
            if (m2f_ack) begin
                n_ack++;
                ack_cyc = cyc;
                if (m2f_viol) n_viol++;
            end
            if (mem_req) n_memreq++;
            if (m2f_frvalid !== (mem_req && mem_gnt && mem_we)) bad_frv++;
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    wmem[mem_addr] = mem_wdata;
                    wr_addr.push_back(mem_addr);
                    wr_dat.push_back(mem_wdata);
                    wbeat++;
                    n_fr++;
                end else begin
                    pq.push_back('{mem_rd(mem_addr),
                                   cyc + int'($urandom_range(lat_min, lat_max))});
                    if (pq.size() > max_out) max_out = pq.size();
                end
            end
            if (f2m_req && !req_q) req_cyc = cyc;
        end
        req_q = f2m_req;
    end

    task automatic clear_stats();
        rd_got.delete(); wr_addr.delete(); wr_dat.delete(); exp_rd.delete();
        wbeat = 0; n_ack = 0; n_viol = 0; n_memreq = 0; n_fr = 0;
        max_out = 0; bad_frv = 0;
        for (int i = 0; i < 64; i++) wsrc[i] = $urandom;
    endtask

    task automatic wait_ack(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #2;
            if (n_ack >= target) begin ok = 1'b1; break; end
            f2m_addr  = 24'($urandom);
            f2m_len   = 6'($urandom);
            f2m_write = 1'($urandom);
        end
    endtask

    task automatic drop_req();
        @(negedge clk);
        @(negedge clk);
        f2m_req = 1'b0;
    endtask

    task automatic do_burst(input logic w, input logic [23:0] a,
                            input logic [5:0] l, output bit ok);
        @(negedge clk);
        clear_stats();
        if (!w && !exp_viol(a, l))
            for (int i = 0; i < int'(l); i++) exp_rd.push_back(mem_rd(a + 24'(i)));
        f2m_write = w; f2m_addr = a; f2m_len = l; f2m_req = 1'b1;
        wait_ack(1, ok);
        drop_req();
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({m2f_ack, m2f_viol, m2f_fwvalid, m2f_frvalid, dma_hrdata, mem_req,
             mem_we, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b req=%b addr=%h want all 0",
                     m2f_ack, mem_req, mem_addr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_vec++;
        if ({m2f_ack, mem_req, m2f_fwvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 000",
                     {m2f_ack, mem_req, m2f_fwvalid});
        end
    endtask

    task automatic test_read_basic();
        bit ok;
        gnt_mode = 0; lat_min = 3; lat_max = 3;
        do_burst(1'b0, 24'h000100, 6'd16, ok);
        repeat (4) @(negedge clk);
        n_vec++;
        if (ok !== 1'b1 || n_ack !== 1 || n_viol !== 0) begin
            n_bad++;
            $display("FAIL rd_ack: got ok=%0d acks=%0d viol=%0d want 1 1 0",
                     ok, n_ack, n_viol);
        end
        n_vec++;
        if (rd_got.size() !== 16) begin
            n_bad++;
            $display("FAIL rd_beats: got %0d want 16", rd_got.size());
        end
        for (int i = 0; i < 16 && i < rd_got.size(); i++) begin
            n_vec++;
            if (rd_got[i] !== exp_rd[i]) begin
                n_bad++;
                $display("FAIL rd_data[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]);
            end
        end
        n_vec++;
        if (max_out > 4) begin
            n_bad++;
            $display("FAIL rd_outstanding: got %0d want <=4", max_out);
        end
    endtask

    task automatic test_write_basic();
        bit ok;
        gnt_mode = 1;
        do_burst(1'b1, 24'h000200, 6'd8, ok);
        n_vec++;
        if (ok !== 1'b1 || n_viol !== 0 || n_fr !== 8 || bad_frv !== 0) begin
            n_bad++;
            $display("FAIL wr_burst: got ok=%0d viol=%0d fr=%0d badfr=%0d want 1 0 8 0",
                     ok, n_viol, n_fr, bad_frv);
        end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            n_vec++;
            if (wr_addr[i] !== 24'h200 + 24'(i) || wr_dat[i] !== wsrc[i]
                || mem_rd(24'h200 + 24'(i)) !== wsrc[i]) begin
                n_bad++;
                $display("FAIL wr_beat[%0d]: got %h/%h want %h/%h", i,
                         wr_addr[i], wr_dat[i], 24'h200 + 24'(i), wsrc[i]);
            end
        end
        n_vec++;
        if (rd_got.size() !== 0) begin
            n_bad++;
            $display("FAIL wr_no_fwvalid: got %0d want 0", rd_got.size());
        end
    endtask

    task automatic test_viol_len();
        bit ok;
        logic [5:0] lens [2];
        lens[0] = 6'd0; lens[1] = 6'd33;
        gnt_mode = 0;
        for (int k = 0; k < 2; k++) begin
            do_burst(1'b0, 24'h000040, lens[k], ok);
            n_vec++;
            if (ok !== 1'b1 || n_viol !== 1 || ack_cyc - req_cyc !== 2) begin
                n_bad++;
                $display("FAIL viol_len%0d: got ok=%0d viol=%0d dt=%0d want 1 1 2",
                         lens[k], ok, n_viol, ack_cyc - req_cyc);
            end
            n_vec++;
            if (n_memreq !== 0 || rd_got.size() !== 0 || n_fr !== 0) begin
                n_bad++;
                $display("FAIL viol_quiet%0d: got memreq=%0d fw=%0d fr=%0d want 0",
                         lens[k], n_memreq, rd_got.size(), n_fr);
            end
        end
    endtask

    task automatic test_window();
        bit ok, v;
        gnt_mode = 2; lat_min = 1; lat_max = 4;
        v = exp_viol(24'h3FFFF8, 6'd16);
        do_burst(1'b0, 24'h3FFFF8, 6'd16, ok);
        n_vec++;
        if (ok !== 1'b1 || n_viol !== int'(v) || (v && n_memreq !== 0)) begin
            n_bad++;
            $display("FAIL window: got ok=%0d viol=%0d memreq=%0d want viol=%0d",
                     ok, n_viol, n_memreq, v);
        end
        n_vec++;
        if (rd_got.size() !== exp_rd.size()) begin
            n_bad++;
            $display("FAIL window_beats: got %0d want %0d", rd_got.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++) begin
            n_vec++;
            if (rd_got[i] !== exp_rd[i]) begin
                n_bad++;
                $display("FAIL window_data[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        logic [23:0] a, b;
        logic [5:0] la, lb;
        gnt_mode = 2; lat_min = 1; lat_max = 4;
        a = 24'($urandom_range(0, 'h3F0000));
        b = 24'($urandom_range(0, 'h3F0000));
        la = 6'($urandom_range(1, 32));
        lb = 6'($urandom_range(1, 32));
        @(negedge clk);
        clear_stats();
        for (int i = 0; i < int'(la); i++) exp_rd.push_back(mem_rd(a + 24'(i)));
        f2m_write = 1'b0; f2m_addr = a; f2m_len = la; f2m_req = 1'b1;
        wait_ack(1, ok1);
        @(negedge clk);
        @(negedge clk);
        f2m_write = 1'b1; f2m_addr = b; f2m_len = lb;
        wait_ack(2, ok2);
        drop_req();
        repeat (10) @(negedge clk);
        n_vec++;
        if (ok1 !== 1'b1 || ok2 !== 1'b1 || n_ack !== 2 || n_viol !== 0) begin
            n_bad++;
            $display("FAIL b2b_acks: got ok=%0d%0d acks=%0d viol=%0d want 11 2 0",
                     ok1, ok2, n_ack, n_viol);
        end
        n_vec++;
        if (rd_got.size() !== int'(la) || wr_addr.size() !== int'(lb)) begin
            n_bad++;
            $display("FAIL b2b_beats: got %0d/%0d want %0d/%0d",
                     rd_got.size(), wr_addr.size(), la, lb);
        end
        for (int i = 0; i < int'(la) && i < rd_got.size(); i++) begin
            n_vec++;
            if (rd_got[i] !== exp_rd[i]) begin
                n_bad++;
                $display("FAIL b2b_rd[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]);
            end
        end
        for (int i = 0; i < int'(lb) && i < wr_addr.size(); i++) begin
            n_vec++;
            if (wr_addr[i] !== b + 24'(i) || wr_dat[i] !== wsrc[i]) begin
                n_bad++;
                $display("FAIL b2b_wr[%0d]: got %h/%h want %h/%h", i,
                         wr_addr[i], wr_dat[i], b + 24'(i), wsrc[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [23:0] a;
        gnt_mode = 0; lat_min = 2; lat_max = 4;
        a = 24'($urandom_range(0, 'h3F0000));
        @(negedge clk);
        clear_stats();
        f2m_write = 1'b0; f2m_addr = a; f2m_len = 6'd16; f2m_req = 1'b1;
        for (int i = 0; i < 300 && rd_got.size() < 5; i++) begin
            @(negedge clk); #2;
        end
        n_vec++;
        if (rd_got.size() < 5) begin
            n_bad++;
            $display("FAIL mid_progress: got %0d beats want >=5", rd_got.size());
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({m2f_ack, m2f_viol, m2f_fwvalid, m2f_frvalid, dma_hrdata, mem_req,
             mem_we, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got req=%b addr=%h hr=%h want 0",
                     mem_req, mem_addr, dma_hrdata);
        end
        f2m_req = 1'b0;
        pq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_stats();
        repeat (5) @(negedge clk);
        n_vec++;
        if (n_ack !== 0 || n_memreq !== 0) begin
            n_bad++;
            $display("FAIL mid_no_ack: got acks=%0d memreq=%0d want 0 0", n_ack, n_memreq);
        end
        do_burst(1'b0, a, 6'd12, ok);
        n_vec++;
        if (ok !== 1'b1 || n_viol !== 0 || rd_got.size() !== 12) begin
            n_bad++;
            $display("FAIL mid_recover: got ok=%0d viol=%0d beats=%0d want 1 0 12",
                     ok, n_viol, rd_got.size());
        end
        for (int i = 0; i < 12 && i < rd_got.size(); i++) begin
            n_vec++;
            if (rd_got[i] !== exp_rd[i]) begin
                n_bad++;
                $display("FAIL mid_data[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok, v;
        logic w;
        logic [23:0] a;
        logic [5:0] l;
        for (int t = 0; t < 40; t++) begin
            gnt_mode = $urandom_range(0, 2);
            lat_min = 1;
            lat_max = $urandom_range(1, 6);
            w = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                l = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
            else
                l = 6'($urandom_range(1, 32));
            if ($urandom_range(0, 4) == 0)
                a = 24'($urandom_range('h3FFFE0, 'h3FFFFF));
            else
                a = 24'($urandom_range(0, 'h3FFFFF));
            v = exp_viol(a, l);
            do_burst(w, a, l, ok);
            n_vec++;
            if (ok !== 1'b1 || n_viol !== int'(v) || bad_frv !== 0) begin
                n_bad++;
                $display("FAIL rnd%0d_ack: got ok=%0d viol=%0d badfr=%0d want 1 %0d 0",
                         t, ok, n_viol, bad_frv, v);
            end
            n_vec++;
            if (v ? (n_memreq !== 0) :
                w ? (wr_addr.size() !== int'(l)) : (rd_got.size() !== int'(l))) begin
                n_bad++;
                $display("FAIL rnd%0d_count: got memreq=%0d wr=%0d rd=%0d len=%0d",
                         t, n_memreq, wr_addr.size(), rd_got.size(), l);
            end
            if (!v && !w)
                for (int i = 0; i < rd_got.size() && i < exp_rd.size(); i++) begin
                    n_vec++;
                    if (rd_got[i] !== exp_rd[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_rd[%0d]: got %h want %h",
                                 t, i, rd_got[i], exp_rd[i]);
                    end
                end
            if (!v && w)
                for (int i = 0; i < wr_addr.size() && i < int'(l); i++) begin
                    n_vec++;
                    if (wr_addr[i] !== a + 24'(i) || wr_dat[i] !== wsrc[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_wr[%0d]: got %h/%h want %h/%h", t, i,
                                 wr_addr[i], wr_dat[i], a + 24'(i), wsrc[i]);
                    end
                end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) wsrc[i] = '0;
        #2 rst = 1'b0;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_viol_len();
        test_window();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
